// File: rtl/spi_bank_pkg.sv
// rtl/spi_bank_pkg.sv - command codes and FSM states shared by the SPI bank loader
package spi_bank_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h02;
   localparam logic [7:0] CMD_READ  = 8'h03;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR_H,
      ST_ADDR_L,
      ST_WR_DATA,
      ST_RD_DATA,
      ST_DROP
   } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - 2-FF synchronizers for sclk/cs_n/mosi with sclk and cs_n edge detection
module spi_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic sclk_i,
   input  logic cs_n_i,
   input  logic mosi_i,
   output logic sclk_rise_o,
   output logic sclk_fall_o,
   output logic cs_n_o,
   output logic cs_fall_o,
   output logic cs_rise_o,
   output logic mosi_o
);

   logic [2:0] sclk_q;
   logic [2:0] cs_q;
   logic [1:0] mosi_q;

   // cs_n resets low so a host already mid-frame produces no falling edge after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_q <= '0;
         cs_q   <= '0;
         mosi_q <= '0;
      end else begin
         sclk_q <= {sclk_q[1:0], sclk_i};
         cs_q   <= {cs_q[1:0], cs_n_i};
         mosi_q <= {mosi_q[0], mosi_i};
      end
   end

   assign sclk_rise_o = sclk_q[1] & ~sclk_q[2];
   assign sclk_fall_o = ~sclk_q[1] & sclk_q[2];
   assign cs_n_o      = cs_q[1];
   assign cs_fall_o   = ~cs_q[1] & cs_q[2];
   assign cs_rise_o   = cs_q[1] & ~cs_q[2];
   assign mosi_o      = mosi_q[1];

endmodule

// File: rtl/spi_bank_loader.sv
// rtl/spi_bank_loader.sv - SPI-slave frame decoder driving one bank write port
// Optional readback (CMD 0x03, MISO path) enabled by SPI_BANK_LOADER_READBACK_EN.
module spi_bank_loader
   import spi_bank_pkg::*;
#(
   parameter int ADDR_WIDTH = 13,
   parameter int DATA_WIDTH = 8,
   parameter int DATA_DEPTH = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  spi_sclk,
   input  logic                  spi_cs_n,
   input  logic                  spi_mosi,
   output logic                  spi_miso,
   output logic [ADDR_WIDTH-1:0] addr_b,
   output logic                  wrenb,
   output logic [DATA_WIDTH-1:0] data_b,
   output logic                  csen,
   output logic [ADDR_WIDTH-1:0] addr_a,
   output logic                  rdena,
   input  logic [DATA_WIDTH-1:0] data_a,
   output logic                  busy,
   output logic                  load_done,
   output logic [ADDR_WIDTH:0]   byte_count
);

   logic sclk_rise, sclk_fall, cs_n_s, cs_fall, cs_rise, mosi_s;

   spi_sync_edge u_sync (
      .clk         (clk),
      .rst_n       (rst_n),
      .sclk_i      (spi_sclk),
      .cs_n_i      (spi_cs_n),
      .mosi_i      (spi_mosi),
      .sclk_rise_o (sclk_rise),
      .sclk_fall_o (sclk_fall),
      .cs_n_o      (cs_n_s),
      .cs_fall_o   (cs_fall),
      .cs_rise_o   (cs_rise),
      .mosi_o      (mosi_s)
   );

   logic [2:0]            bitcnt_q, bitcnt_d;
   logic [DATA_WIDTH-2:0] rx_q, rx_d;

   always_comb begin
      bitcnt_d = bitcnt_q;
      rx_d     = rx_q;
      if (cs_n_s) begin
         bitcnt_d = '0;
      end else if (sclk_rise) begin
         bitcnt_d = bitcnt_q + 3'd1;
         rx_d     = {rx_q[DATA_WIDTH-3:0], mosi_s};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bitcnt_q <= '0;
         rx_q     <= '0;
      end else begin
         bitcnt_q <= bitcnt_d;
         rx_q     <= rx_d;
      end
   end

   // The completing byte is taken straight from the shifter so a byte ending
   // together with cs_n rising is still written before the frame closes.
   logic                  byte_done;
   logic [DATA_WIDTH-1:0] byte_w;
   assign byte_done = sclk_rise && (bitcnt_q == 3'd7);
   assign byte_w    = {rx_q, mosi_s};

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] addr_q, addr_b_q;
   logic [7:0]            addr_hi_q;
   logic [DATA_WIDTH-1:0] data_b_q;
   logic [ADDR_WIDTH:0]   byte_count_q;
   logic                  wrenb_q, csen_q, busy_q, load_done_q, ld_pend_q;
   logic                  wr_now, cmd_ok;
   logic [ADDR_WIDTH-1:0] start_addr;

   assign wr_now     = (state_q == ST_WR_DATA) && byte_done;
   assign start_addr = ADDR_WIDTH'({addr_hi_q, byte_w});

   function automatic logic [ADDR_WIDTH-1:0] addr_next(input logic [ADDR_WIDTH-1:0] a);
      return (a == ADDR_WIDTH'(DATA_DEPTH - 1)) ? '0 : a + ADDR_WIDTH'(1);
   endfunction

`ifdef SPI_BANK_LOADER_READBACK_EN
   logic                  is_rd_q, rdena_q, rd_pend_q, miso_q;
   logic [ADDR_WIDTH-1:0] addr_a_q;
   logic [DATA_WIDTH-1:0] tx_q;
   assign cmd_ok   = (byte_w == CMD_WRITE) || (byte_w == CMD_READ);
   assign spi_miso = miso_q;
   assign rdena    = rdena_q;
   assign addr_a   = addr_a_q;
`else
   logic unused_rb;
   assign cmd_ok    = (byte_w == CMD_WRITE);
   assign spi_miso  = 1'b0;
   assign rdena     = 1'b0;
   assign addr_a    = '0;
   assign unused_rb = ^{data_a, sclk_fall};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         addr_hi_q    <= '0;
         addr_b_q     <= '0;
         data_b_q     <= '0;
         byte_count_q <= '0;
         wrenb_q      <= 1'b0;
         csen_q       <= 1'b0;
         busy_q       <= 1'b0;
         load_done_q  <= 1'b0;
         ld_pend_q    <= 1'b0;
`ifdef SPI_BANK_LOADER_READBACK_EN
         is_rd_q      <= 1'b0;
         rdena_q      <= 1'b0;
         rd_pend_q    <= 1'b0;
         miso_q       <= 1'b0;
         addr_a_q     <= '0;
         tx_q         <= '0;
`endif
      end else begin
         wrenb_q     <= 1'b0;
         csen_q      <= 1'b0;
         ld_pend_q   <= 1'b0;
         load_done_q <= ld_pend_q;
`ifdef SPI_BANK_LOADER_READBACK_EN
         rdena_q     <= 1'b0;
         rd_pend_q   <= rdena_q;
`endif
         if (wr_now) begin
            wrenb_q  <= 1'b1;
            csen_q   <= 1'b1;
            addr_b_q <= addr_q;
            data_b_q <= byte_w;
            addr_q   <= addr_next(addr_q);
            if (~&byte_count_q)
               byte_count_q <= byte_count_q + (ADDR_WIDTH+1)'(1);
         end

         if ((state_q != ST_IDLE) && cs_rise) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            ld_pend_q <= (byte_count_q != '0) || wr_now;
`ifdef SPI_BANK_LOADER_READBACK_EN
            miso_q    <= 1'b0;
`endif
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (cs_fall) begin
                     state_q      <= ST_CMD;
                     busy_q       <= 1'b1;
                     byte_count_q <= '0;
                  end
               end
               ST_CMD: begin
                  if (byte_done) begin
                     state_q <= cmd_ok ? ST_ADDR_H : ST_DROP;
`ifdef SPI_BANK_LOADER_READBACK_EN
                     is_rd_q <= (byte_w == CMD_READ);
`endif
                  end
               end
               ST_ADDR_H: begin
                  if (byte_done) begin
                     addr_hi_q <= byte_w;
                     state_q   <= ST_ADDR_L;
                  end
               end
               ST_ADDR_L: begin
                  if (byte_done) begin
                     addr_q  <= start_addr;
                     state_q <= ST_WR_DATA;
`ifdef SPI_BANK_LOADER_READBACK_EN
                     if (is_rd_q) begin
                        state_q  <= ST_RD_DATA;
                        rdena_q  <= 1'b1;
                        csen_q   <= 1'b1;
                        addr_a_q <= start_addr;
                     end
`endif
                  end
               end
`ifdef SPI_BANK_LOADER_READBACK_EN
               ST_RD_DATA: begin
                  if (byte_done) begin
                     addr_q   <= addr_next(addr_q);
                     rdena_q  <= 1'b1;
                     csen_q   <= 1'b1;
                     addr_a_q <= addr_next(addr_q);
                  end
                  // MSB is presented on load; the fall closing a byte must not shift it away
                  if (rd_pend_q) begin
                     miso_q <= data_a[DATA_WIDTH-1];
                     tx_q   <= {data_a[DATA_WIDTH-2:0], 1'b0};
                  end else if (sclk_fall && (bitcnt_q != 3'd0)) begin
                     miso_q <= tx_q[DATA_WIDTH-1];
                     tx_q   <= {tx_q[DATA_WIDTH-2:0], 1'b0};
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

   assign addr_b     = addr_b_q;
   assign wrenb      = wrenb_q;
   assign data_b     = data_b_q;
   assign csen       = csen_q;
   assign busy       = busy_q;
   assign load_done  = load_done_q;
   assign byte_count = byte_count_q;

endmodule

// File: tb/tb_spi_bank_loader.sv
// tb/tb_spi_bank_loader.sv - table-driven frame checks plus busy latency, reset and readback sequences
module tb_spi_bank_loader;

   logic        clk;
   logic        rst_n;
   logic        spi_sclk, spi_cs_n, spi_mosi, spi_miso;
   logic [12:0] addr_b, addr_a;
   logic        wrenb, csen, rdena, busy, load_done;
   logic [7:0]  data_b, data_a;
   logic [13:0] byte_count;

   spi_bank_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .spi_sclk   (spi_sclk),
      .spi_cs_n   (spi_cs_n),
      .spi_mosi   (spi_mosi),
      .spi_miso   (spi_miso),
      .addr_b     (addr_b),
      .wrenb      (wrenb),
      .data_b     (data_b),
      .csen       (csen),
      .addr_a     (addr_a),
      .rdena      (rdena),
      .data_a     (data_a),
      .busy       (busy),
      .load_done  (load_done),
      .byte_count (byte_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] mem [0:1023];
   always @(posedge clk) begin
      if (!rst_n) data_a <= 8'h00;
      else begin
         if (wrenb) mem[addr_b[9:0]] <= data_b;
         if (rdena) data_a <= mem[addr_a[9:0]];
      end
   end

   int total, bad;
   int ld_cnt, wide_err, csen_err;
   logic prev_wr;
   logic [15:0] wr_addr_q [$];
   logic [7:0]  wr_data_q [$];
   logic [7:0]  rx_buf [8];

   always @(negedge clk) begin
      if (wrenb) begin
         wr_addr_q.push_back({3'b000, addr_b});
         wr_data_q.push_back(data_b);
      end
      if (wrenb && prev_wr) wide_err++;
      prev_wr = wrenb;
      if (csen !== (wrenb | rdena)) csen_err++;
      if (load_done) ld_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] rx);
      logic [7:0] r;
      r = 8'h00;
      for (int k = 0; k < n; k++) begin
         spi_mosi = b[7-k];
         #40;
         r = {r[6:0], spi_miso};
         spi_sclk = 1'b1;
         #40;
         spi_sclk = 1'b0;
      end
      rx = r;
   endtask

   task automatic xfer(input logic [0:7][7:0] b, input int nb, input int cut);
      logic [7:0] r;
      spi_cs_n = 1'b0;
      #40;
      for (int i = 0; i < nb; i++) begin
         spi_bits(b[i], 8, r);
         rx_buf[i] = r;
      end
      if (cut > 0) spi_bits(b[nb], cut, r);
      #40;
      spi_cs_n = 1'b1;
      #300;
   endtask

   task automatic clear_log();
      wr_addr_q.delete();
      wr_data_q.delete();
      ld_cnt = 0;
   endtask

   typedef struct packed {
      logic [0:7][7:0]  bytes;
      int               nbytes;
      int               cut;
      int               exp_n;
      logic [0:3][15:0] exp_addr;
      logic [0:3][7:0]  exp_data;
      int               exp_count;
      int               exp_ld;
   } vec_t;

   vec_t vecs [8];
   int   n;

   initial begin
      total = 0; bad = 0; ld_cnt = 0; wide_err = 0; csen_err = 0; prev_wr = 1'b0;
      rst_n = 1'b0; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;

      vecs[0] = '{bytes:64'h020010AABBCC0000, nbytes:6, cut:0, exp_n:3,
                  exp_addr:64'h0010_0011_0012_0000, exp_data:32'hAABBCC00, exp_count:3, exp_ld:1};
      vecs[1] = '{bytes:64'h0203FF1234000000, nbytes:5, cut:0, exp_n:2,
                  exp_addr:64'h03FF_0000_0000_0000, exp_data:32'h12340000, exp_count:2, exp_ld:1};
      vecs[2] = '{bytes:64'h0200405A6B000000, nbytes:4, cut:5, exp_n:1,
                  exp_addr:64'h0040_0000_0000_0000, exp_data:32'h5A000000, exp_count:1, exp_ld:1};
      vecs[3] = '{bytes:64'h5502001077000000, nbytes:5, cut:0, exp_n:0,
                  exp_addr:64'h0, exp_data:32'h0, exp_count:0, exp_ld:0};
      vecs[4] = '{bytes:64'h0200001100000000, nbytes:4, cut:0, exp_n:1,
                  exp_addr:64'h0000_0000_0000_0000, exp_data:32'h11000000, exp_count:1, exp_ld:1};
      vecs[5] = '{bytes:64'h02E0077700000000, nbytes:4, cut:0, exp_n:1,
                  exp_addr:64'h0007_0000_0000_0000, exp_data:32'h77000000, exp_count:1, exp_ld:1};
      vecs[6] = '{bytes:64'h0300200000000000, nbytes:4, cut:0, exp_n:0,
                  exp_addr:64'h0, exp_data:32'h0, exp_count:0, exp_ld:0};
      vecs[7] = '{bytes:64'h0200300000000000, nbytes:3, cut:0, exp_n:0,
                  exp_addr:64'h0, exp_data:32'h0, exp_count:0, exp_ld:0};

      repeat (3) @(negedge clk);
      check("reset_busy", {31'd0, busy}, 0);
      check("reset_wr_outs", {addr_b, data_b, wrenb, csen, load_done, rdena, spi_miso}, 0);
      check("reset_byte_count", {18'd0, byte_count}, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 8; v++) begin
         clear_log();
         xfer(vecs[v].bytes, vecs[v].nbytes, vecs[v].cut);
         check($sformatf("v%0d_nwrites", v), wr_addr_q.size(), vecs[v].exp_n);
         for (int k = 0; k < vecs[v].exp_n && k < wr_addr_q.size(); k++) begin
            check($sformatf("v%0d_addr%0d", v, k), {16'd0, wr_addr_q[k]}, {16'd0, vecs[v].exp_addr[k]});
            check($sformatf("v%0d_data%0d", v, k), {24'd0, wr_data_q[k]}, {24'd0, vecs[v].exp_data[k]});
         end
         check($sformatf("v%0d_byte_count", v), {18'd0, byte_count}, vecs[v].exp_count);
         check($sformatf("v%0d_load_done", v), ld_cnt, vecs[v].exp_ld);
         check($sformatf("v%0d_busy_after", v), {31'd0, busy}, 0);
      end

      // busy follows cs_n by three clocks in both directions
      @(negedge clk);
      spi_cs_n = 1'b0;
      n = 0;
      while (!busy && n < 20) begin @(negedge clk); n++; end
      check("busy_rise_lag", n, 3);
      spi_cs_n = 1'b1;
      n = 0;
      while (busy && n < 20) begin @(negedge clk); n++; end
      check("busy_fall_lag", n, 3);
      #200;

      // reset in the middle of a data byte
      clear_log();
      spi_cs_n = 1'b0;
      #40;
      spi_bits(8'h02, 8, rx_buf[0]);
      spi_bits(8'h01, 8, rx_buf[0]);
      spi_bits(8'h00, 8, rx_buf[0]);
      spi_bits(8'hA5, 8, rx_buf[0]);
      spi_bits(8'h3C, 4, rx_buf[0]);
      check("pre_reset_count", {18'd0, byte_count}, 1);
      rst_n = 1'b0;
      #1;
      check("mid_reset_outs", {addr_b, data_b, wrenb, csen, load_done, busy}, 0);
      check("mid_reset_count", {18'd0, byte_count}, 0);
      #9;
      #20;
      rst_n = 1'b1;
      clear_log();
      spi_bits(8'h3C, 4, rx_buf[0]);
      spi_bits(8'h02, 8, rx_buf[0]);
      spi_bits(8'h00, 8, rx_buf[0]);
      spi_bits(8'h55, 8, rx_buf[0]);
      check("post_reset_ignored_busy", {31'd0, busy}, 0);
      #40;
      spi_cs_n = 1'b1;
      #300;
      check("post_reset_no_writes", wr_addr_q.size(), 0);
      check("post_reset_no_done", ld_cnt, 0);
      xfer(64'h0200609900000000, 4, 0);
      check("recover_nwrites", wr_addr_q.size(), 1);
      if (wr_addr_q.size() > 0) begin
         check("recover_addr", {16'd0, wr_addr_q[0]}, 32'h60);
         check("recover_data", {24'd0, wr_data_q[0]}, 32'h99);
      end
      check("recover_done", ld_cnt, 1);

`ifdef SPI_BANK_LOADER_READBACK_EN
      xfer(64'h0200205AC3000000, 5, 0);
      clear_log();
      xfer(64'h0300200000000000, 5, 0);
      check("rb_byte0", {24'd0, rx_buf[3]}, 32'h5A);
      check("rb_byte1", {24'd0, rx_buf[4]}, 32'hC3);
      check("rb_no_writes", wr_addr_q.size(), 0);
      check("rb_no_done", ld_cnt, 0);
`else
      clear_log();
      xfer(64'h0300200000000000, 5, 0);
      check("rd_dropped_miso", {24'd0, rx_buf[3] | rx_buf[4]}, 0);
      check("rd_dropped_no_writes", wr_addr_q.size(), 0);
`endif

      check("wrenb_single_clk", wide_err, 0);
      check("csen_tracks_strobes", csen_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
